// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// dff_bank_arbiter : round-robin write arbiter sharing one WIDTH-bit DFF bank
// Revision: 1.0
// ============================================================================
module dff_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         LOCK,
  input  logic [N_REQ*WIDTH-1:0]   WDATA,
  output logic [N_REQ-1:0]         GNT,
  output logic [WIDTH-1:0]         Q,
  output logic [WIDTH-1:0]         QN,
  output logic                     UPD,
  output logic                     BUSY
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] C_LAST_IDX  = PW'(N_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_owner, w_owner_nxt, w_owner_inc;
  logic [PW-1:0]    w_base, w_winner;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_upd;
  logic             w_found, w_write, w_release;

  assign w_owner_inc = (r_owner == C_LAST_IDX) ? '0 : r_owner + 1'b1;
  // On release the scan starts just past the owner, so it only re-wins when alone.
  assign w_base = (r_state == S_OWNED) ? w_owner_inc : r_ptr;

  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(w_base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && REQ[idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_write     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWNED;
          w_gnt_nxt   = N_REQ'(1) << w_winner;
          w_owner_nxt = w_winner;
          w_hold_nxt  = '0;
        end
      end
      S_OWNED: begin
        w_write   = REQ[r_owner];
        w_release = !REQ[r_owner] || !LOCK[r_owner] || (r_hold == C_HOLD_LAST);
        if (w_release) begin
          w_ptr_nxt  = w_owner_inc;
          w_hold_nxt = '0;
          if (w_found) begin
            w_gnt_nxt   = N_REQ'(1) << w_winner;
            w_owner_nxt = w_winner;
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
          end
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_q     <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
      r_upd   <= w_write;
      if (w_write) r_q <= WDATA[int'(r_owner)*WIDTH +: WIDTH];
    end
  end

  assign GNT  = r_gnt;
  assign Q    = r_q;
  assign QN   = ~r_q;
  assign UPD  = r_upd;
  assign BUSY = |r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dff_bank_arbiter : directed self-checking bench for dff_bank_arbiter
// Revision: 1.0
// ============================================================================
module tb_dff_bank_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                   CLK;
  logic                   RSTN;
  logic [N_REQ-1:0]       REQ;
  logic [N_REQ-1:0]       LOCK;
  logic [N_REQ*WIDTH-1:0] WDATA;
  logic [N_REQ-1:0]       GNT;
  logic [WIDTH-1:0]       Q;
  logic [WIDTH-1:0]       QN;
  logic                   UPD;
  logic                   BUSY;

  int tests_run = 0;
  int tests_failed = 0;

  dff_bank_arbiter #(
    .N_REQ   (N_REQ),
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .REQ  (REQ),
    .LOCK (LOCK),
    .WDATA(WDATA),
    .GNT  (GNT),
    .Q    (Q),
    .QN   (QN),
    .UPD  (UPD),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] gnt, input logic [7:0] q,
                           input logic upd);
    chk({tag, ".gnt"}, 32'(GNT), 32'(gnt));
    chk({tag, ".q"},   32'(Q),   32'(q));
    chk({tag, ".upd"}, 32'(UPD), 32'(upd));
  endtask

  task automatic set_wd(input int i, input logic [7:0] v);
    WDATA[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    RSTN  = 1'b0;
    REQ   = 4'b1111;
    LOCK  = 4'b1111;
    WDATA = 32'hDEAD_BEEF;

    // Reset held two edges with every requester asserting
    tick();
    tick();
    chk_state("reset", 4'b0000, 8'h00, 1'b0);
    chk("reset.qn",   32'(QN),   32'hFF);
    chk("reset.busy", 32'(BUSY), 32'h0);

    // Round robin, no locks; first grant one edge after reset release
    @(negedge CLK);
    RSTN = 1'b1;
    LOCK = 4'b0000;
    for (int i = 0; i < N_REQ; i++) set_wd(i, 8'(8'h10 + i));
    tick();
    chk_state("rr0", 4'b0001, 8'h00, 1'b0);
    chk("rr0.busy", 32'(BUSY), 32'h1);
    tick();
    chk_state("rr1", 4'b0010, 8'h10, 1'b1);
    tick();
    chk_state("rr2", 4'b0100, 8'h11, 1'b1);
    tick();
    chk_state("rr3", 4'b1000, 8'h12, 1'b1);
    tick();
    chk_state("rr4", 4'b0001, 8'h13, 1'b1);

    // Requester 0 drops while owning: no write, nobody pending -> IDLE
    @(negedge CLK);
    REQ = 4'b0000;
    tick();
    chk_state("idle", 4'b0000, 8'h13, 1'b0);
    chk("idle.busy", 32'(BUSY), 32'h0);

    // Single requester re-wins every cycle
    @(negedge CLK);
    REQ = 4'b0100;
    set_wd(2, 8'hA5);
    tick();
    chk_state("single1", 4'b0100, 8'h13, 1'b0);
    tick();
    chk_state("single2", 4'b0100, 8'hA5, 1'b1);
    chk("single2.qn", 32'(QN), 32'h5A);
    @(negedge CLK);
    REQ = 4'b0000;
    tick();
    chk_state("single3", 4'b0000, 8'hA5, 1'b0);

    // Hold limit: locked requester 0 writes exactly MAX_HOLD times (ptr=3 -> 0 wins)
    @(negedge CLK);
    REQ  = 4'b0011;
    LOCK = 4'b0001;
    set_wd(1, 8'h21);
    tick();
    chk_state("hold.g", 4'b0001, 8'hA5, 1'b0);
    for (int n = 0; n < MAX_HOLD; n++) begin
      @(negedge CLK);
      set_wd(0, 8'(8'h20 + n));
      tick();
      chk_state($sformatf("hold.w%0d", n), (n == MAX_HOLD - 1) ? 4'b0010 : 4'b0001,
                8'(8'h20 + n), 1'b1);
    end
    tick();
    chk_state("hold.r1", 4'b0001, 8'h21, 1'b1);

    // Early drop: requester 0 (locked) drops after 2 writes while 3 pending
    @(negedge CLK);
    REQ = 4'b1001;
    set_wd(0, 8'h30);
    tick();
    chk_state("drop.w0", 4'b0001, 8'h30, 1'b1);
    @(negedge CLK);
    set_wd(0, 8'h31);
    tick();
    chk_state("drop.w1", 4'b0001, 8'h31, 1'b1);
    @(negedge CLK);
    REQ = 4'b1000;
    set_wd(0, 8'h32);
    tick();
    chk_state("drop.x", 4'b1000, 8'h31, 1'b0);

    // Owner 3 drops, requester 1 takes over without a bubble
    @(negedge CLK);
    REQ  = 4'b0010;
    LOCK = 4'b0000;
    set_wd(1, 8'h3C);
    tick();
    chk_state("mid.g", 4'b0010, 8'h31, 1'b0);

    // Reset mid-grant discards the pending write
    @(negedge CLK);
    RSTN = 1'b0;
    tick();
    chk_state("mid.rst", 4'b0000, 8'h00, 1'b0);
    chk("mid.rst.qn", 32'(QN), 32'hFF);
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    chk_state("mid.regrant", 4'b0010, 8'h00, 1'b0);
    tick();
    chk_state("mid.write", 4'b0010, 8'h3C, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin write arbiter that shares one WIDTH-bit bank of D flip-flops between N_REQ requesters.
- Grants one requester at a time, muxes its write data into the bank and exposes Q/QN.
- A locked requester may hold the bank for up to MAX_HOLD consecutive writes.
- Sits between multiple control agents and a shared status/config register.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the shared register bank.
- MAX_HOLD, 4, maximum consecutive grant cycles for a locked requester (>=1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTN  input  1  synchronous, active-low reset.
- REQ  input  N_REQ  per-requester write request.
- LOCK  input  N_REQ  per-requester hold request; sampled only while that requester is granted.
- WDATA  input  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- GNT  output  N_REQ  registered one-hot grant (or all zero).
- Q  output  WIDTH  shared register bank contents.
- QN  output  WIDTH  bitwise inverse of Q (combinational).
- UPD  output  1  registered pulse; high for the cycle after Q was written.
- BUSY  output  1  equals |GNT.

Behaviour:
- Reset: synchronous. On a rising CLK with RSTN=0, all of the following take effect regardless of other inputs:
  - GNT=0, Q=0, QN=all ones, UPD=0, BUSY=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state=IDLE.
  - No write occurs on that edge.
- Reset mid-grant: the grant is revoked at that edge and the data is discarded.
- States: IDLE (GNT=0) and OWNED (GNT one-hot, owner index g).
- Arbitration function: pick the first set bit of REQ scanning ptr, ptr+1, ... modulo N_REQ.
- IDLE:
  - REQ=0: stay IDLE.
  - Otherwise, at the edge: GNT<=onehot(winner), hold_cnt<=0, state<=OWNED.
  - No write on the grant edge; grant latency is 1 cycle.
- OWNED, at each edge:
  - Write: if REQ[g]=1, Q<=WDATA[g] and UPD<=1; else UPD<=0 and Q holds.
  - Release: occurs if REQ[g]=0, or LOCK[g]=0, or hold_cnt=MAX_HOLD-1.
  - On release, ptr<=(g+1) mod N_REQ and arbitration is re-run on the current REQ using the new ptr:
    - Winner found: GNT moves to the winner on the same edge, hold_cnt<=0. No idle bubble.
    - No winner: GNT<=0, state<=IDLE.
    - g itself may re-win only if no other requester is pending.
  - No release: hold_cnt<=hold_cnt+1 and GNT holds.
- UPD is 0 in IDLE and whenever no write occurred on the previous edge.
- LOCK is ignored for requesters that are not granted. REQ/LOCK are synchronous to CLK.
- hold_cnt width is clog2(MAX_HOLD), minimum 1. With MAX_HOLD=1, every write releases.
- With no contention, a locked requester is re-granted immediately after release, so Q may be written every cycle indefinitely.
- A requester dropping REQ while granted forfeits the grant with no write on that edge.

Test Plan:
- Reset:
  - Stimulus: RSTN=0 for 2 edges with REQ=1111.
  - Required: GNT=0000, Q=0x00, QN=0xFF, UPD=0, BUSY=0.
  - After RSTN=1: first grant is GNT=0001 one edge later.
- Single requester:
  - Stimulus: REQ=0100, LOCK=0000, WDATA[2]=0xA5.
  - Edge1: GNT=0100, Q=0x00.
  - Edge2: Q=0xA5, QN=0x5A, UPD=1, GNT remains 0100 (re-win).
  - Edge3: REQ=0 gives GNT=0000, UPD=0.
- Round robin:
  - Stimulus: REQ=1111, LOCK=0000, WDATA[i]=0x10+i.
  - Required: GNT sequence 0001,0010,0100,1000,0001 on consecutive edges.
  - Q sequence lags one edge: 0x10,0x11,0x12,0x13, with UPD=1 continuously.
- Hold limit:
  - Stimulus: REQ=0011, LOCK=0001.
  - Required: requester 0 writes exactly 4 consecutive cycles, then GNT=0010.
  - Requester 1 then writes once (LOCK=0), then GNT returns to 0001.
- Early drop:
  - Stimulus: GNT=0001 with LOCK=0001; REQ[0] drops after 2 writes while REQ[3]=1.
  - Required on that edge: no write (Q keeps the last requester-0 value), UPD=0, GNT=1000.
- Reset mid-operation:
  - Stimulus: RSTN=0 for one edge while GNT=0010 and REQ[1]=1, WDATA[1]=0x3C.
  - Required: Q=0x00 (not 0x3C), GNT=0000.
  - After release with REQ=0010: GNT=0010 one edge later.
